// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the sequential multiply/divide unit, its decoder and the
// shared ALU wrapper.
package muldiv_seq_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REMU = 2'b10,
    OP_RSVD = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [4:0] STEP_LAST = 5'd31;

  // Operations that finish without iterating: divide by zero and the reserved op.
  function automatic logic is_short_op(input md_op_e op_v, input logic [31:0] divisor_v);
    logic short_v;
    case (op_v)
      OP_MUL:  short_v = 1'b0;
      OP_DIVU: short_v = (divisor_v == 32'd0);
      OP_REMU: short_v = (divisor_v == 32'd0);
      OP_RSVD: short_v = 1'b1;
      default: short_v = 1'b1;
    endcase
    return short_v;
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative 32-bit MUL / DIVU / REMU unit that borrows the shared ALU one step per
// cycle (shift-add multiply, restoring divide); 32 RUN cycles per operation.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic        clk,
  input  logic        Rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        alu_own,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  input  logic [31:0] alu_res,
  input  logic        alu_lt
);

  md_state_e   state_r;
  md_state_e   state_nxt_s;
  md_op_e      op_r;
  md_op_e      op_in_s;
  logic [4:0]  cnt_r;
  // acc_r: product accumulator (MUL) or partial remainder (DIV).
  // mcand_r: shifted multiplicand (MUL) or divisor (DIV).
  // mplier_r: multiplier (MUL) or dividend shifting into quotient (DIV).
  logic [31:0] acc_r;
  logic [31:0] mcand_r;
  logic [31:0] mplier_r;
  logic [31:0] result_r;
  logic        ready_r;
  logic        busy_r;
  logic        done_r;
  logic        own_r;

  logic        accept_s;
  logic        short_s;
  logic [31:0] trial_s;
  logic        sub_s;
  logic [31:0] acc_step_s;
  logic [31:0] mcand_step_s;
  logic [31:0] mplier_step_s;
  logic [31:0] run_res_s;
  logic [31:0] short_res_s;

  assign op_in_s  = md_op_e'(op);
  assign accept_s = start & (state_r == ST_IDLE) & ~flush;
  assign short_s  = is_short_op(op_in_s, opb);
  assign trial_s  = {acc_r[30:0], mplier_r[31]};
  assign sub_s    = acc_r[31] | ~alu_lt;

  assign ready   = ready_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign result  = result_r;
  assign alu_own = own_r;

  // Shared-ALU operand drive; forced to zero whenever this block does not own it.
  always_comb begin
    alu_a   = 32'd0;
    alu_b   = 32'd0;
    alu_sel = 3'b000;
    if (state_r == ST_RUN) begin
      case (op_r)
        OP_MUL: begin
          alu_sel = ALU_ADD;
          alu_a   = acc_r;
          alu_b   = mcand_r;
        end
        OP_DIVU, OP_REMU: begin
          alu_sel = ALU_SUB;
          alu_a   = trial_s;
          alu_b   = mcand_r;
        end
        default: begin
          alu_sel = 3'b000;
          alu_a   = 32'd0;
          alu_b   = 32'd0;
        end
      endcase
    end else begin
      alu_sel = 3'b000;
      alu_a   = 32'd0;
      alu_b   = 32'd0;
    end
  end

  // One iteration of the datapath using the ALU result of this cycle.
  always_comb begin
    acc_step_s    = acc_r;
    mcand_step_s  = mcand_r;
    mplier_step_s = mplier_r;
    case (op_r)
      OP_MUL: begin
        if (mplier_r[0]) begin
          acc_step_s = alu_res;
        end else begin
          acc_step_s = acc_r;
        end
        mcand_step_s  = {mcand_r[30:0], 1'b0};
        mplier_step_s = {1'b0, mplier_r[31:1]};
      end
      OP_DIVU, OP_REMU: begin
        if (sub_s) begin
          acc_step_s    = alu_res;
          mplier_step_s = {mplier_r[30:0], 1'b1};
        end else begin
          acc_step_s    = trial_s;
          mplier_step_s = {mplier_r[30:0], 1'b0};
        end
      end
      default: begin
        acc_step_s    = acc_r;
        mplier_step_s = mplier_r;
      end
    endcase
  end

  // Result candidates for the iterative and the immediate completion paths.
  always_comb begin
    run_res_s   = 32'd0;
    short_res_s = 32'd0;
    case (op_r)
      OP_MUL:  run_res_s = acc_step_s;
      OP_DIVU: run_res_s = mplier_step_s;
      OP_REMU: run_res_s = acc_step_s;
      default: run_res_s = 32'd0;
    endcase
    case (op_in_s)
      OP_DIVU: short_res_s = 32'hFFFF_FFFF;
      OP_REMU: short_res_s = opa;
      default: short_res_s = 32'd0;
    endcase
  end

  // Next-state logic; flush aborts RUN and DONE back to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = short_s ? ST_DONE : ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == 5'd0) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_r  <= ST_IDLE;
      op_r     <= OP_MUL;
      cnt_r    <= 5'd0;
      acc_r    <= 32'd0;
      mcand_r  <= 32'd0;
      mplier_r <= 32'd0;
      result_r <= 32'd0;
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      own_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == ST_IDLE);
      busy_r  <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DONE);
      done_r  <= (state_nxt_s == ST_DONE);
      own_r   <= (state_nxt_s == ST_RUN);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r  <= op_in_s;
            acc_r <= 32'd0;
            if (op_in_s == OP_MUL) begin
              mcand_r  <= opa;
              mplier_r <= opb;
            end else begin
              mcand_r  <= opb;
              mplier_r <= opa;
            end
            if (short_s) begin
              result_r <= short_res_s;
            end else begin
              cnt_r <= STEP_LAST;
            end
          end
        end
        ST_RUN: begin
          if (!flush) begin
            acc_r    <= acc_step_s;
            mcand_r  <= mcand_step_s;
            mplier_r <= mplier_step_s;
            if (cnt_r == 5'd0) begin
              result_r <= run_res_s;
            end else begin
              cnt_r <= cnt_r - 5'd1;
            end
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed vector bench for muldiv_seq with a behavioural model of the shared ALU.
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        flush;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        alu_own;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_sel;
  logic [31:0] alu_res;
  logic        alu_lt;

  int total;
  int bad;
  int own_cnt;
  int done_cnt;
  int idle_alu_bad;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  muldiv_seq dut (
    .clk(clk), .Rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .flush(flush), .ready(ready), .busy(busy), .done(done), .result(result),
    .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_res(alu_res), .alu_lt(alu_lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU behaviour: 000 add, 001 subtract, unsigned less-than flag.
  always_comb begin
    alu_res = 32'd0;
    if (alu_sel == 3'b000) alu_res = alu_a + alu_b;
    else if (alu_sel == 3'b001) alu_res = alu_a - alu_b;
    alu_lt = (alu_a < alu_b);
  end

  always @(negedge clk) begin
    if (alu_own) own_cnt++;
    if (done) done_cnt++;
    if (!alu_own && (alu_a != 32'd0 || alu_b != 32'd0 || alu_sel != 3'd0)) idle_alu_bad++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int owned);
    int own0;
    own0  = own_cnt;
    op    = o;
    opa   = a;
    opb   = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    opa   = 32'hDEAD_BEEF;
    opb   = 32'h0BAD_0BAD;
    op    = 2'b11;
    lat   = 1;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res    = result;
    owned  = own_cnt - own0;
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] prior;
    int lat;
    int owned;
    int d0;
    total = 0; bad = 0; own_cnt = 0; done_cnt = 0; idle_alu_bad = 0;
    vecs[0]  = '{2'b00, 32'd7,          32'd6,          32'd42,         33};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  33};
    vecs[2]  = '{2'b01, 32'd100,        32'd7,          32'd14,         33};
    vecs[3]  = '{2'b10, 32'd100,        32'd7,          32'd2,          33};
    vecs[4]  = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
    vecs[5]  = '{2'b01, 32'h8000_0001,  32'h8000_0000,  32'd1,          33};
    vecs[6]  = '{2'b10, 32'h8000_0001,  32'h8000_0000,  32'd1,          33};
    vecs[7]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[8]  = '{2'b10, 32'd5,          32'd0,          32'd5,          1};
    vecs[9]  = '{2'b11, 32'd9,          32'd9,          32'd0,          1};
    vecs[10] = '{2'b00, 32'h0001_0000,  32'h0001_0000,  32'd0,          33};
    vecs[11] = '{2'b00, 32'd12345,      32'd1000,       32'd12345000,   33};
    vecs[12] = '{2'b10, 32'hFFFF_FFFF,  32'h0000_0010,  32'h0000_000F,  33};
    vecs[13] = '{2'b01, 32'd3,          32'd10,         32'd0,          33};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; opa = 32'd0; opb = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_own", {31'd0, alu_own}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, owned);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_alu_own_cycles", i), owned, (vecs[i].lat == 1) ? 32'd0 : 32'd32);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), {30'd0, done, ready}, 32'd1);
    end

    // Flush at RUN cycle 10: back to IDLE, no done, previous result kept.
    prior = result;
    d0 = done_cnt;
    op = 2'b00; opa = 32'd3; opb = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_ready", {31'd0, ready}, 32'd1);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_no_done", done_cnt - d0, 32'd0);
    chk("flush_result_kept", result, prior);
    run_op(2'b01, 32'd100, 32'd7, res, lat, owned);
    chk("after_flush_result", res, 32'd14);
    @(posedge clk); #1;

    // Reset at RUN cycle 20.
    op = 2'b00; opa = 32'd7; opb = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_own", {31'd0, alu_own}, 32'd0);
    chk("midrst_alu_a", alu_a, 32'd0);

    // start held high while busy must not queue a second operation.
    d0 = done_cnt;
    op = 2'b00; opa = 32'd3; opb = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    op = 2'b01; opa = 32'd100; opb = 32'd7;
    repeat (20) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("busy_start_done_count", done_cnt - d0, 32'd1);
    chk("busy_start_result", result, 32'd15);

    chk("alu_zero_when_not_owned", idle_alu_bad, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
